// File: rtl/toy_mem_pkg.sv
// Shared types and limits for the unified-memory arbiter.
// Return tags carry {valid, src} so read data can be routed back to its issuer.
package toy_mem_pkg;

  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  localparam int RD_LAT_MAX   = 4;
  localparam int MAX_WAIT_MAX = 15;

  typedef struct packed {
    logic valid;
    logic src;
  } ret_tag_t;

endpackage

// File: rtl/toy_ret_tag_pipe.sv
// Fixed-depth shift register of return tags; the last stage marks which port
// owns the SRAM read data presented in the current cycle.
module toy_ret_tag_pipe
  import toy_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     CLK,
  input  logic     RST,
  input  ret_tag_t push_tag,
  output logic     ret_valid,
  output logic     ret_src
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      ret_tag_t tag_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge CLK) begin
          if (RST) tag_reg <= '0;
          else     tag_reg <= push_tag;
        end
      end else begin : g_body
        always_ff @(posedge CLK) begin
          if (RST) tag_reg <= '0;
          else     tag_reg <= g_stage[gi-1].tag_reg;
        end
      end
    end
  endgenerate

  assign ret_valid = g_stage[DEPTH-1].tag_reg.valid;
  assign ret_src   = g_stage[DEPTH-1].tag_reg.src;

endmodule

// File: rtl/toy_mem_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and data ports.
// Data wins by default; a starvation counter forces an instruction grant.
module toy_mem_arbiter
  import toy_mem_pkg::*;
#(
  parameter int AW       = 30,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IREQ,
  input  logic [AW-1:0]    IADDR,
  output logic             IGNT,
  output logic             IRDY,
  output logic [DW-1:0]    INSTR,
  input  logic             DREQ,
  input  logic             DRW,
  input  logic [AW-1:0]    DADDR,
  input  logic [DW-1:0]    DWDATA,
  output logic             DGNT,
  output logic             DRDY,
  output logic [DW-1:0]    DRDATA,
  output logic             MREQ,
  output logic             MRW,
  output logic [AW-1:0]    MADDR,
  output logic [DW-1:0]    MWDATA,
  input  logic [DW-1:0]    MRDATA,
  output logic [CNT_W-1:0] CONFLICT_CNT
);

  // Out-of-range parameters are clamped into the supported window.
  localparam int RD_LAT_C   = (RD_LAT < 1) ? 1 :
                              ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);
  localparam int MAX_WAIT_C = (MAX_WAIT < 1) ? 1 :
                              ((MAX_WAIT > MAX_WAIT_MAX) ? MAX_WAIT_MAX : MAX_WAIT);
  localparam logic [3:0] MAX_WAIT_V = 4'(MAX_WAIT_C);

  logic [3:0]       starve_cnt_reg, starve_cnt_next;
  logic [CNT_W-1:0] conflict_cnt_reg, conflict_cnt_next;
  logic             mreq_reg, mrw_reg;
  logic [AW-1:0]    maddr_reg;
  logic [DW-1:0]    mwdata_reg;
  logic             ignt, dgnt;
  ret_tag_t         push_tag;
  logic             ret_valid, ret_src;

  always_comb begin
    ignt = 1'b0;
    dgnt = 1'b0;
    if (!RST) begin
      if (IREQ && DREQ) begin
        if (starve_cnt_reg == MAX_WAIT_V) ignt = 1'b1;
        else                              dgnt = 1'b1;
      end else if (DREQ) begin
        dgnt = 1'b1;
      end else if (IREQ) begin
        ignt = 1'b1;
      end
    end
  end

  assign IGNT = ignt;
  assign DGNT = dgnt;

  // A loss can only happen below MAX_WAIT, so the counter never passes it.
  always_comb begin
    starve_cnt_next = 4'd0;
    if (IREQ && !ignt) starve_cnt_next = starve_cnt_reg + 4'd1;
  end

  always_comb begin
    conflict_cnt_next = conflict_cnt_reg;
    if (IREQ && DREQ && (conflict_cnt_reg != {CNT_W{1'b1}}))
      conflict_cnt_next = conflict_cnt_reg + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_cnt_reg   <= 4'd0;
      conflict_cnt_reg <= '0;
    end else begin
      starve_cnt_reg   <= starve_cnt_next;
      conflict_cnt_reg <= conflict_cnt_next;
    end
  end

  // Address/data fields hold when idle; only MREQ drops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mreq_reg   <= 1'b0;
      mrw_reg    <= 1'b0;
      maddr_reg  <= '0;
      mwdata_reg <= '0;
    end else if (dgnt) begin
      mreq_reg   <= 1'b1;
      mrw_reg    <= DRW;
      maddr_reg  <= DADDR;
      mwdata_reg <= DWDATA;
    end else if (ignt) begin
      mreq_reg   <= 1'b1;
      mrw_reg    <= 1'b0;
      maddr_reg  <= IADDR;
      mwdata_reg <= '0;
    end else begin
      mreq_reg   <= 1'b0;
    end
  end

  assign MREQ         = mreq_reg;
  assign MRW          = mrw_reg;
  assign MADDR        = maddr_reg;
  assign MWDATA       = mwdata_reg;
  assign CONFLICT_CNT = conflict_cnt_reg;

  // Writes push an empty slot so later reads keep their fixed latency.
  always_comb begin
    push_tag.valid = ignt | (dgnt & ~DRW);
    push_tag.src   = dgnt ? SRC_D : SRC_I;
  end

  toy_ret_tag_pipe #(
    .DEPTH (1 + RD_LAT_C)
  ) u_ret_pipe (
    .CLK       (CLK),
    .RST       (RST),
    .push_tag  (push_tag),
    .ret_valid (ret_valid),
    .ret_src   (ret_src)
  );

  assign IRDY   = !RST && ret_valid && (ret_src == SRC_I);
  assign DRDY   = !RST && ret_valid && (ret_src == SRC_D);
  assign INSTR  = MRDATA;
  assign DRDATA = MRDATA;

endmodule
